ifetch_prefetch_ctrl: RTL and testbench
=======================================

// Module: ifetch_prefetch_ctrl
// PURPOSE
//  Fetch sequencer for the byte-addressed, big-endian instruction memory (combinational read, 32-bit word).
//  Owns the fetch PC, drives the memory ReadAddress, and buffers fetched words and their PCs in a DEPTH-entry FIFO.
//  Hands instructions to decode over a valid/ready handshake and accepts branch/jump redirects that flush the queue.
// PARAMETERS
//  ADDR_W    10  byte-address width; matches the memory ReadAddress width.
//  DEPTH     4   prefetch queue entries; power of 2, >= 2.
//  RESET_PC  0   fetch PC loaded at reset; must be word aligned.
// PORTS
//  Clk          in   1       single clock; all state updates on the rising edge.
//  ResetN       in   1       synchronous, active-low reset.
//  ReadAddress  out  ADDR_W  byte address to the instruction memory; always equals FetchPC.
//  Instruction  in   32      word returned by the memory for ReadAddress in the same cycle.
//  Redirect     in   1       one-cycle pulse: flush the queue and restart fetch at RedirectPC.
//  RedirectPC   in   ADDR_W  redirect target byte address.
//  Halt         in   1       level: suspend enqueuing; the queue keeps draining.
//  InstrValid   out  1       queue head is valid.
//  InstrReady   in   1       decode accepts the head; handshake when InstrValid & InstrReady.
//  InstrOut     out  32      head instruction; 0 when InstrValid=0.
//  InstrPC      out  ADDR_W  byte address of the head instruction; 0 when InstrValid=0.
//  QueueCount   out  $clog2(DEPTH)+1  occupied entries.
//  MisalignErr  out  1       sticky misaligned-redirect flag (see CONFIGURATION).
// BEHAVIOUR
//  Reset (ResetN=0 at an edge):
//   - FetchPC=RESET_PC; queue emptied; FSM=RUN.
//   - InstrValid=0, InstrOut=0, InstrPC=0, QueueCount=0, MisalignErr=0.
//  FSM states:
//   - RUN: enqueue allowed; Halt=1 -> IDLE.
//   - IDLE: no enqueue; Halt=0 -> RUN.
//   - TRAP: exists only with the CONFIGURATION macro; no enqueue; exits only by reset.
//   - Redirect in RUN or IDLE: next state is RUN if Halt=0, else IDLE.
//  Enqueue condition: state==RUN & Halt=0 & Redirect=0 & (count<DEPTH | pop).
//   - pop = InstrValid & InstrReady.
//   - On enqueue: the entry stores {Instruction, FetchPC}, then FetchPC <= FetchPC+4.
//   - FetchPC wraps modulo 2^ADDR_W: 0x3FC -> 0x000.
//  Latency:
//   - A word fetched at cycle N is at the head, with InstrValid=1, from cycle N+1 when the queue was empty.
//   - Sustained throughput is 1 instruction/cycle with InstrReady held at 1.
//  Full: count==DEPTH with no pop -> no enqueue; FetchPC holds; ReadAddress is stable.
//  Full + pop in the same cycle: the pop and the enqueue both occur; count stays DEPTH.
//  Empty: InstrValid=0; InstrReady is ignored; count never underflows.
//  Redirect at an edge:
//   - The queue is flushed (count=0) and FetchPC <= RedirectPC with bits[1:0] cleared.
//   - No enqueue that cycle.
//   - A pop in the same cycle is still a completed transfer for decode; the flush applies after it.
//   - InstrValid=0 the next cycle; the target instruction is valid 2 cycles after Redirect, provided Halt=0.
//  Redirect + Halt together: PC reloads and the queue flushes; FSM goes to IDLE; no fetch until Halt=0.
//  Reset has priority over Redirect, Halt and handshakes; reset mid-stream discards all queued entries.
// CONFIGURATION
//  Macro IFETCH_MISALIGN_TRAP_EN.
//  Defined:
//   - A Redirect with RedirectPC[1:0]!=0 sets MisalignErr=1 (sticky) and flushes the queue.
//   - FSM enters TRAP; FetchPC is left unchanged.
//   - Only reset clears the trap.
//  Undefined:
//   - RedirectPC[1:0] are silently cleared; MisalignErr is tied to 0.
//   - TRAP state is not built.
// TESTING
//  1. Reset, then release with InstrReady=1 and memory words W0..W3 at 0x000..0x00C:
//     InstrOut=W0,W1,W2,W3 on consecutive cycles from cycle 1; InstrPC=0x000,0x004,0x008,0x00C.
//  2. InstrReady=0 for 10 cycles:
//     QueueCount saturates at 4; ReadAddress holds at 0x010; release -> W0..W3 then W4 with no gap or duplicate.
//  3. Redirect with RedirectPC=0x100 while the queue is full:
//     next cycle QueueCount=0, InstrValid=0, ReadAddress=0x100; the word from 0x100 is valid 2 cycles after the pulse.
//  4. FetchPC=0x3FC, stream running: InstrPC sequence 0x3FC, 0x000, 0x004.
//  5. Halt=1 with 3 queued and InstrReady=1:
//     the 3 entries drain, then InstrValid=0 and ReadAddress holds; Halt=0 resumes at the held address.
//  6. Redirect with RedirectPC=0x102:
//     macro defined -> MisalignErr=1, no further InstrValid until reset;
//     undefined -> fetch restarts at 0x100, MisalignErr=0.

Source files
------------

// File: rtl/ifetch_prefetch_ctrl.sv
// Instruction fetch sequencer with a DEPTH-entry prefetch queue and redirect flush.
// Optional misaligned-redirect trap is built when IFETCH_MISALIGN_TRAP_EN is defined.
module ifetch_prefetch_ctrl #(
  parameter int                ADDR_W   = 10,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                       Clk,
  input  logic                       ResetN,
  output logic [ADDR_W-1:0]          ReadAddress,
  input  logic [31:0]                Instruction,
  input  logic                       Redirect,
  input  logic [ADDR_W-1:0]          RedirectPC,
  input  logic                       Halt,
  output logic                       InstrValid,
  input  logic                       InstrReady,
  output logic [31:0]                InstrOut,
  output logic [ADDR_W-1:0]          InstrPC,
  output logic [$clog2(DEPTH):0]     QueueCount,
  output logic                       MisalignErr
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

`ifdef IFETCH_MISALIGN_TRAP_EN
  typedef enum logic [1:0] {S_RUN, S_IDLE, S_TRAP} state_t;
`else
  typedef enum logic [0:0] {S_RUN, S_IDLE} state_t;
`endif

  state_t              state_q;
  logic [ADDR_W-1:0]   fetch_pc_q;
  logic [PW-1:0]       rd_ptr_q;
  logic [PW-1:0]       wr_ptr_q;
  logic [CW-1:0]       count_q;
  logic [31:0]         instr_mem [DEPTH];
  logic [ADDR_W-1:0]   pc_mem    [DEPTH];

  logic                pop;
  logic                full;
  logic                enq;
  logic [ADDR_W-1:0]   redir_tgt_d;
  state_t              redir_state_d;

  assign pop           = (count_q != '0) & InstrReady;
  assign full          = (count_q == CW'(DEPTH));
  assign enq           = (state_q == S_RUN) & ~Halt & ~Redirect & (~full | pop);
  assign redir_tgt_d   = RedirectPC & ~ADDR_W'(3);
  assign redir_state_d = Halt ? S_IDLE : S_RUN;

`ifdef IFETCH_MISALIGN_TRAP_EN
  logic misalign_q;
  logic misaligned;
  assign misaligned  = (RedirectPC[1:0] != 2'b00);
  assign MisalignErr = misalign_q;
`else
  assign MisalignErr = 1'b0;
`endif

  always_ff @(posedge Clk) begin
    if (!ResetN) begin
      state_q    <= S_RUN;
      fetch_pc_q <= RESET_PC;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
`ifdef IFETCH_MISALIGN_TRAP_EN
      misalign_q <= 1'b0;
`endif
    end else if (Redirect) begin
      // A same-cycle pop has already been taken by decode; the flush discards the rest.
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
`ifdef IFETCH_MISALIGN_TRAP_EN
      if (state_q == S_TRAP) begin
        state_q <= S_TRAP;
      end else if (misaligned) begin
        misalign_q <= 1'b1;
        state_q    <= S_TRAP;
      end else begin
        fetch_pc_q <= redir_tgt_d;
        state_q    <= redir_state_d;
      end
`else
      fetch_pc_q <= redir_tgt_d;
      state_q    <= redir_state_d;
`endif
    end else begin
      case (state_q)
        S_RUN:   if (Halt)  state_q <= S_IDLE;
        S_IDLE:  if (!Halt) state_q <= S_RUN;
        default: state_q <= state_q;
      endcase
      if (enq) begin
        wr_ptr_q   <= wr_ptr_q + 1'b1;
        fetch_pc_q <= fetch_pc_q + ADDR_W'(4);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      if (enq && !pop) begin
        count_q <= count_q + 1'b1;
      end else if (pop && !enq) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

  // Queue storage carries no reset; occupancy is tracked by the pointers and count.
  always_ff @(posedge Clk) begin
    if (enq) begin
      instr_mem[wr_ptr_q] <= Instruction;
      pc_mem[wr_ptr_q]    <= fetch_pc_q;
    end
  end

  assign ReadAddress = fetch_pc_q;
  assign QueueCount  = count_q;
  assign InstrValid  = (count_q != '0);
  assign InstrOut    = InstrValid ? instr_mem[rd_ptr_q] : 32'd0;
  assign InstrPC     = InstrValid ? pc_mem[rd_ptr_q] : '0;

endmodule

// File: tb/tb_ifetch_prefetch_ctrl.sv
// Directed bench for ifetch_prefetch_ctrl; memory word at byte address a is {16'hC0DE, 6'b0, a}.
// Trap-path expectations follow IFETCH_MISALIGN_TRAP_EN.
module tb_ifetch_prefetch_ctrl;

  logic        Clk = 1'b0;
  logic        ResetN;
  logic [9:0]  ReadAddress;
  logic [31:0] Instruction;
  logic        Redirect;
  logic [9:0]  RedirectPC;
  logic        Halt;
  logic        InstrValid;
  logic        InstrReady;
  logic [31:0] InstrOut;
  logic [9:0]  InstrPC;
  logic [2:0]  QueueCount;
  logic        MisalignErr;

  int tests = 0;
  int fails = 0;

  ifetch_prefetch_ctrl #(.ADDR_W(10), .DEPTH(4), .RESET_PC(10'h000)) dut (
    .Clk         (Clk),
    .ResetN      (ResetN),
    .ReadAddress (ReadAddress),
    .Instruction (Instruction),
    .Redirect    (Redirect),
    .RedirectPC  (RedirectPC),
    .Halt        (Halt),
    .InstrValid  (InstrValid),
    .InstrReady  (InstrReady),
    .InstrOut    (InstrOut),
    .InstrPC     (InstrPC),
    .QueueCount  (QueueCount),
    .MisalignErr (MisalignErr)
  );

  always #5 Clk = ~Clk;

  assign Instruction = {16'hC0DE, 6'b000000, ReadAddress};

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    ResetN     = 1'b0;
    Redirect   = 1'b0;
    RedirectPC = 10'h000;
    Halt       = 1'b0;
    InstrReady = 1'b1;
    step();
    step();
    chk("rst_valid", {31'd0, InstrValid}, 32'd0);
    chk("rst_out",   InstrOut, 32'd0);
    chk("rst_pc",    {22'd0, InstrPC}, 32'd0);
    chk("rst_count", {29'd0, QueueCount}, 32'd0);
    chk("rst_addr",  {22'd0, ReadAddress}, 32'h000);
    chk("rst_merr",  {31'd0, MisalignErr}, 32'd0);

    // 1: streaming from reset
    ResetN = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("s1_valid", {31'd0, InstrValid}, 32'd1);
      chk("s1_out",   InstrOut, 32'hC0DE_0000 + 32'(i * 4));
      chk("s1_pc",    {22'd0, InstrPC}, 32'(i * 4));
    end
    chk("s1_count", {29'd0, QueueCount}, 32'd1);

    // 2: backpressure from reset, then release
    ResetN     = 1'b0;
    InstrReady = 1'b0;
    step();
    ResetN = 1'b1;
    for (int i = 0; i < 10; i++) step();
    chk("s2_count_sat", {29'd0, QueueCount}, 32'd4);
    chk("s2_addr_hold", {22'd0, ReadAddress}, 32'h010);
    InstrReady = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("s2_out", InstrOut, 32'hC0DE_0000 + 32'(i * 4));
      chk("s2_pc",  {22'd0, InstrPC}, 32'(i * 4));
      if (i < 4) begin
        step();
        chk("s2_count_full", {29'd0, QueueCount}, 32'd4);
      end
    end

    // 3: redirect while full
    InstrReady = 1'b0;
    Redirect   = 1'b1;
    RedirectPC = 10'h100;
    step();
    Redirect = 1'b0;
    chk("s3_count", {29'd0, QueueCount}, 32'd0);
    chk("s3_valid", {31'd0, InstrValid}, 32'd0);
    chk("s3_addr",  {22'd0, ReadAddress}, 32'h100);
    chk("s3_out0",  InstrOut, 32'd0);
    InstrReady = 1'b1;
    step();
    chk("s3_valid2", {31'd0, InstrValid}, 32'd1);
    chk("s3_out",    InstrOut, 32'hC0DE_0100);
    chk("s3_pc",     {22'd0, InstrPC}, 32'h100);

    // 4: PC wrap
    Redirect   = 1'b1;
    RedirectPC = 10'h3FC;
    step();
    Redirect = 1'b0;
    step();
    chk("s4_pc0",  {22'd0, InstrPC}, 32'h3FC);
    chk("s4_out0", InstrOut, 32'hC0DE_03FC);
    step();
    chk("s4_pc1",  {22'd0, InstrPC}, 32'h000);
    step();
    chk("s4_pc2",  {22'd0, InstrPC}, 32'h004);

    // 5: halt with 3 queued, drain, resume
    InstrReady = 1'b0;
    step();
    step();
    chk("s5_count3", {29'd0, QueueCount}, 32'd3);
    chk("s5_addr",   {22'd0, ReadAddress}, 32'h010);
    Halt       = 1'b1;
    InstrReady = 1'b1;
    step();
    chk("s5_count2", {29'd0, QueueCount}, 32'd2);
    chk("s5_head8",  {22'd0, InstrPC}, 32'h008);
    step();
    chk("s5_headC",  {22'd0, InstrPC}, 32'h00C);
    step();
    chk("s5_empty",  {31'd0, InstrValid}, 32'd0);
    step();
    chk("s5_count0", {29'd0, QueueCount}, 32'd0);
    chk("s5_hold",   {22'd0, ReadAddress}, 32'h010);
    Halt = 1'b0;
    step();
    step();
    chk("s5_resume_v",  {31'd0, InstrValid}, 32'd1);
    chk("s5_resume_pc", {22'd0, InstrPC}, 32'h010);

    // 5b: redirect together with halt
    Halt       = 1'b1;
    Redirect   = 1'b1;
    RedirectPC = 10'h200;
    step();
    Redirect = 1'b0;
    chk("s5b_count", {29'd0, QueueCount}, 32'd0);
    chk("s5b_addr",  {22'd0, ReadAddress}, 32'h200);
    step();
    chk("s5b_nofetch", {31'd0, InstrValid}, 32'd0);
    Halt = 1'b0;
    step();
    step();
    chk("s5b_pc", {22'd0, InstrPC}, 32'h200);

    // 6: misaligned redirect
    Redirect   = 1'b1;
    RedirectPC = 10'h102;
    step();
    Redirect = 1'b0;
    chk("s6_count", {29'd0, QueueCount}, 32'd0);
`ifdef IFETCH_MISALIGN_TRAP_EN
    chk("s6_merr", {31'd0, MisalignErr}, 32'd1);
    chk("s6_addr", {22'd0, ReadAddress}, 32'h204);
    for (int i = 0; i < 4; i++) step();
    chk("s6_trap_valid", {31'd0, InstrValid}, 32'd0);
    chk("s6_trap_merr",  {31'd0, MisalignErr}, 32'd1);
    ResetN = 1'b0;
    step();
    ResetN = 1'b1;
    chk("s6_rst_merr", {31'd0, MisalignErr}, 32'd0);
    step();
    chk("s6_rst_pc", {22'd0, InstrPC}, 32'h000);
`else
    chk("s6_merr", {31'd0, MisalignErr}, 32'd0);
    chk("s6_addr", {22'd0, ReadAddress}, 32'h100);
    step();
    chk("s6_valid", {31'd0, InstrValid}, 32'd1);
    chk("s6_pc",    {22'd0, InstrPC}, 32'h100);
`endif

    // reset mid-stream discards queued entries
    InstrReady = 1'b0;
    step();
    step();
    ResetN = 1'b0;
    step();
    chk("rst2_count", {29'd0, QueueCount}, 32'd0);
    chk("rst2_addr",  {22'd0, ReadAddress}, 32'h000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
